// File: rtl/musa_pkg.sv
// musa_pkg: stage encodings, opcodes and opcode-class helpers for the MUSA stage sequencer.
package musa_pkg;
  typedef enum logic [2:0] {
    S_IFH  = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } stage_t;
  localparam logic [5:0] OP_R_TYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [5:0] OP_SUBI   = 6'b001010;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_JR     = 6'b001011;
  localparam logic [5:0] OP_JPC    = 6'b001001;
  localparam logic [5:0] OP_BRFL   = 6'b010001;
  localparam logic [5:0] OP_HALT   = 6'b000010;
  localparam logic [5:0] OP_NOP    = 6'b000001;
  localparam logic [5:0] OP_CALL   = 6'b000011;
  localparam logic [5:0] OP_RET    = 6'b000111;
  function automatic logic is_alu(input logic [5:0] op);
    return op inside {OP_R_TYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI};
  endfunction
  function automatic logic is_known(input logic [5:0] op);
    return is_alu(op) || (op inside {OP_LW, OP_SW, OP_JR, OP_JPC, OP_BRFL, OP_HALT, OP_NOP, OP_CALL, OP_RET});
  endfunction
endpackage

// File: rtl/musa_wait_timer.sv
// musa_wait_timer: counts consecutive wait cycles; expired flags the last allowed wait cycle.
module musa_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(LIMIT - 1);
endmodule

// File: rtl/musa_stage_sequencer.sv
// musa_stage_sequencer: steps each instruction IFH->ID->EX->[MEM]->[WB] and drives per-stage strobes.
module musa_stage_sequencer
  import musa_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             cond_flag,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_busy,
  output logic [2:0]       stage,
  output logic             imem_req,
  output logic             ir_load,
  output logic             pc_inc,
  output logic             rf_read_en,
  output logic             alu_start,
  output logic             pc_load,
  output logic             stack_push,
  output logic             stack_pop,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             rf_write_en,
  output logic             illegal_op,
  output logic             bus_error,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);
  stage_t     state, nxt;
  logic [5:0] opcode_q;
  logic       ex_first, retire, timeout, waiting, expired;
  assign stage = state;
  assign waiting = (state == S_IFH && !imem_ready) || (state == S_MEM && !dmem_ready);
  musa_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst_n(rst_n), .clr(!waiting), .inc(waiting), .expired(expired)
  );
  // Strobes are gated by rst_n so an asserted reset silences every output at once.
  always_comb begin
    nxt = state;
    {imem_req, ir_load, pc_inc, rf_read_en, alu_start, pc_load, stack_push, stack_pop} = '0;
    {dmem_req, dmem_we, rf_write_en, illegal_op, halted, retire, timeout} = '0;
    if (rst_n)
      case (state)
        S_IFH: begin
          imem_req = 1'b1;
          {ir_load, pc_inc} = {2{imem_ready}};
          timeout = !imem_ready && expired;
          nxt = imem_ready ? S_ID : timeout ? S_HALT : S_IFH;
        end
        S_ID: begin
          rf_read_en = 1'b1;
          illegal_op = !is_known(opcode);
          retire = opcode == OP_NOP;
          nxt = opcode == OP_HALT ? S_HALT : (retire || illegal_op) ? S_IFH : S_EX;
        end
        S_EX: begin
          if (is_alu(opcode_q)) begin
            alu_start = ex_first;
            nxt = alu_busy ? S_EX : S_WB;
          end else if (opcode_q == OP_LW || opcode_q == OP_SW) begin
            alu_start = 1'b1;
            nxt = S_MEM;
          end else begin
            pc_load = opcode_q == OP_BRFL ? cond_flag : 1'b1;
            stack_push = opcode_q == OP_CALL;
            stack_pop = opcode_q == OP_RET;
            retire = 1'b1;
            nxt = S_IFH;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we = opcode_q == OP_SW;
          retire = dmem_ready && dmem_we;
          timeout = !dmem_ready && expired;
          nxt = dmem_ready ? (dmem_we ? S_IFH : S_WB) : timeout ? S_HALT : S_MEM;
        end
        S_WB: begin
          rf_write_en = 1'b1;
          retire = 1'b1;
          nxt = S_IFH;
        end
        default: halted = 1'b1;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IFH;
      opcode_q <= '0;
      ex_first <= 1'b0;
      instret <= '0;
      bus_error <= 1'b0;
    end else begin
      state <= nxt;
      if (state == S_ID) opcode_q <= opcode;
      ex_first <= nxt == S_EX && state != S_EX;
      if (retire) instret <= instret + CNT_W'(1);
      if (timeout) bus_error <= 1'b1;
    end
endmodule

// File: tb/tb_musa_stage_sequencer.sv
// tb_musa_stage_sequencer: per-instruction expected traces built from the stage rules, replayed cycle by cycle.
module tb_musa_stage_sequencer;
  import musa_pkg::*;
  localparam int O_IREQ = 12, O_IRL = 11, O_PCI = 10, O_RFR = 9, O_ALS = 8, O_PCL = 7, O_PSH = 6;
  localparam int O_POP = 5, O_DRQ = 4, O_DWE = 3, O_RFW = 2, O_ILL = 1, O_HLT = 0;
  logic clk = 0, rst_n = 0, cond_flag = 0, imem_ready = 0, dmem_ready = 0, alu_busy = 0;
  logic [5:0] opcode = '0;
  logic [2:0] stage, t_stage;
  logic imem_req, ir_load, pc_inc, rf_read_en, alu_start, pc_load, stack_push, stack_pop;
  logic dmem_req, dmem_we, rf_write_en, illegal_op, bus_error, halted;
  logic t_imem_req, t_ir_load, t_pc_inc, t_rf_read_en, t_alu_start, t_pc_load, t_stack_push, t_stack_pop;
  logic t_dmem_req, t_dmem_we, t_rf_write_en, t_illegal_op, t_bus_error, t_halted;
  logic [31:0] instret, t_instret, exp_instret = '0;
  logic [12:0] outs, t_outs;
  int errors = 0, checks = 0;
  typedef struct {int st; logic [12:0] o; logic ir, dr, ab, cf; logic [5:0] op;} cyc_t;
  cyc_t q[$];
  logic [5:0] ops[14] = '{OP_R_TYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_LW, OP_SW,
                          OP_JR, OP_JPC, OP_BRFL, OP_HALT, OP_NOP, OP_CALL, OP_RET};
  always #5 clk = ~clk;
  musa_stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond_flag(cond_flag), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_busy(alu_busy), .stage(stage), .imem_req(imem_req), .ir_load(ir_load),
    .pc_inc(pc_inc), .rf_read_en(rf_read_en), .alu_start(alu_start), .pc_load(pc_load),
    .stack_push(stack_push), .stack_pop(stack_pop), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .rf_write_en(rf_write_en), .illegal_op(illegal_op), .bus_error(bus_error), .halted(halted),
    .instret(instret)
  );
  musa_stage_sequencer #(.MEM_TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .cond_flag(cond_flag), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .alu_busy(alu_busy), .stage(t_stage), .imem_req(t_imem_req), .ir_load(t_ir_load),
    .pc_inc(t_pc_inc), .rf_read_en(t_rf_read_en), .alu_start(t_alu_start), .pc_load(t_pc_load),
    .stack_push(t_stack_push), .stack_pop(t_stack_pop), .dmem_req(t_dmem_req), .dmem_we(t_dmem_we),
    .rf_write_en(t_rf_write_en), .illegal_op(t_illegal_op), .bus_error(t_bus_error), .halted(t_halted),
    .instret(t_instret)
  );
  assign outs = {imem_req, ir_load, pc_inc, rf_read_en, alu_start, pc_load, stack_push, stack_pop,
                 dmem_req, dmem_we, rf_write_en, illegal_op, halted};
  assign t_outs = {t_imem_req, t_ir_load, t_pc_inc, t_rf_read_en, t_alu_start, t_pc_load, t_stack_push,
                   t_stack_pop, t_dmem_req, t_dmem_we, t_rf_write_en, t_illegal_op, t_halted};
  function automatic logic [12:0] b(input int k);
    return 13'(1) << k;
  endfunction
  function automatic logic r1();
    return 1'($urandom);
  endfunction
  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction
  task automatic add(input int st, input logic [12:0] o, input logic ir, dr, ab, cf, input logic [5:0] op);
    cyc_t e;
    e.st = st; e.o = o; e.ir = ir; e.dr = dr; e.ab = ab; e.cf = cf; e.op = op;
    q.push_back(e);
  endtask
  // Expected cycle trace of one instruction; ready/busy/cond are random wherever they must be ignored.
  task automatic build(input logic [5:0] op, input int iw, bw, dw, input logic cf, output int ret);
    bit known = 0;
    foreach (ops[i]) if (ops[i] == op) known = 1;
    q.delete();
    ret = 0;
    for (int i = 0; i < iw; i++) add(0, b(O_IREQ), 0, r1(), r1(), r1(), r6());
    add(0, b(O_IREQ) | b(O_IRL) | b(O_PCI), 1, r1(), r1(), r1(), r6());
    add(1, b(O_RFR) | (known ? 13'b0 : b(O_ILL)), r1(), r1(), r1(), r1(), op);
    if (op == OP_HALT) begin
      for (int i = 0; i < 20; i++) add(5, b(O_HLT), r1(), r1(), r1(), r1(), r6());
      return;
    end
    if (!known || op == OP_NOP) begin
      ret = known ? 1 : 0;
      return;
    end
    ret = 1;
    if (op inside {OP_R_TYPE, OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI}) begin
      for (int k = 0; k <= bw; k++) add(2, k == 0 ? b(O_ALS) : 13'b0, r1(), r1(), k < bw, r1(), r6());
      add(4, b(O_RFW), r1(), r1(), r1(), r1(), r6());
    end else if (op == OP_LW || op == OP_SW) begin
      add(2, b(O_ALS), r1(), r1(), r1(), r1(), r6());
      for (int k = 0; k <= dw; k++)
        add(3, b(O_DRQ) | (op == OP_SW ? b(O_DWE) : 13'b0), r1(), k == dw, r1(), r1(), r6());
      if (op == OP_LW) add(4, b(O_RFW), r1(), r1(), r1(), r1(), r6());
    end else if (op == OP_BRFL) begin
      add(2, cf ? b(O_PCL) : 13'b0, r1(), r1(), r1(), cf, r6());
    end else begin
      add(2, b(O_PCL) | (op == OP_CALL ? b(O_PSH) : 13'b0) | (op == OP_RET ? b(O_POP) : 13'b0),
          r1(), r1(), r1(), r1(), r6());
    end
  endtask
  task automatic play(input int n, input string tag);
    for (int i = 0; i < q.size() && i < n; i++) begin
      imem_ready = q[i].ir; dmem_ready = q[i].dr; alu_busy = q[i].ab; cond_flag = q[i].cf; opcode = q[i].op;
      #1;
      checks++;
      if (stage !== 3'(q[i].st)) begin
        errors++; $display("FAIL %s cyc%0d stage got %0d exp %0d", tag, i, stage, q[i].st);
      end
      checks++;
      if (outs !== q[i].o) begin
        errors++; $display("FAIL %s cyc%0d strobes got %b exp %b", tag, i, outs, q[i].o);
      end
      checks++;
      if (instret !== exp_instret) begin
        errors++; $display("FAIL %s cyc%0d instret got %0d exp %0d", tag, i, instret, exp_instret);
      end
      checks++;
      if (bus_error !== 1'b0) begin
        errors++; $display("FAIL %s cyc%0d bus_error got %b exp 0", tag, i, bus_error);
      end
      @(negedge clk);
    end
  endtask
  task automatic run(input logic [5:0] op, input int iw, bw, dw, input logic cf, input string tag);
    int ret;
    build(op, iw, bw, dw, cf, ret);
    play(1000, tag);
    exp_instret += 32'(ret);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; imem_ready = 0; dmem_ready = 0; alu_busy = 0;
    @(negedge clk);
    rst_n = 1;
    exp_instret = '0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    rst_n = 0; imem_ready = 1; dmem_ready = 1; alu_busy = 1; opcode = OP_LW;
    #1;
    checks++;
    if (stage !== 3'd0 || outs !== 13'b0) begin
      errors++; $display("FAIL reset stage/strobes got %0d/%b exp 0/0", stage, outs);
    end
    checks++;
    if (instret !== 32'd0 || bus_error !== 1'b0) begin
      errors++; $display("FAIL reset instret/bus_error got %0d/%b exp 0/0", instret, bus_error);
    end
    checks++;
    if (t_stage !== 3'd0 || t_outs !== 13'b0 || t_bus_error !== 1'b0) begin
      errors++; $display("FAIL reset_t got %0d/%b/%b exp 0/0/0", t_stage, t_outs, t_bus_error);
    end
    @(negedge clk);
    rst_n = 1; imem_ready = 0;
    exp_instret = '0;
  endtask
  task automatic test_r_type();
    run(OP_R_TYPE, 0, 0, 0, 0, "r_type");
    #1;
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL r_type_instret got %0d exp 1", instret);
    end
  endtask
  task automatic test_alu_busy();
    run(OP_R_TYPE, 1, 3, 0, 0, "alu_busy");
    run(OP_ADDI, 2, 1, 0, 0, "addi");
  endtask
  task automatic test_lw_sw();
    run(OP_LW, 1, 0, 2, 0, "lw");
    run(OP_SW, 0, 0, 1, 0, "sw");
    run(OP_SW, 0, 0, 0, 0, "sw_fast");
  endtask
  task automatic test_flow();
    run(OP_CALL, 0, 0, 0, 0, "call");
    run(OP_RET, 0, 0, 0, 0, "ret");
    run(OP_BRFL, 0, 0, 0, 0, "brfl_nt");
    run(OP_BRFL, 1, 0, 0, 1, "brfl_t");
    run(OP_JR, 0, 0, 0, 0, "jr");
    run(OP_JPC, 0, 0, 0, 0, "jpc");
    run(OP_NOP, 0, 0, 0, 0, "nop");
  endtask
  task automatic test_illegal();
    run(6'b111111, 0, 0, 0, 0, "illegal");
    run(6'b010101, 1, 0, 0, 0, "illegal2");
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      op = ops[$urandom_range(0, 13)];
      if (op == OP_HALT) op = r6();
      if (op == OP_HALT) op = 6'b111110;
      run(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), r1(), "random");
    end
  endtask
  task automatic test_reset_mid_mem();
    int ret;
    build(OP_LW, 0, 0, 10, 0, ret);
    play(5, "pre_rst");
    #2 rst_n = 0; imem_ready = 1; dmem_ready = 1;
    #1;
    checks++;
    if (stage !== 3'd0 || outs !== 13'b0) begin
      errors++; $display("FAIL rst_mid_mem stage/strobes got %0d/%b exp 0/0", stage, outs);
    end
    checks++;
    if (instret !== 32'd0) begin
      errors++; $display("FAIL rst_mid_mem instret got %0d exp 0", instret);
    end
    @(negedge clk);
    rst_n = 1; imem_ready = 0;
    exp_instret = '0;
    run(OP_SW, 0, 0, 0, 0, "after_rst");
  endtask
  task automatic test_halt();
    run(OP_HALT, 0, 0, 0, 0, "halt");
    do_reset();
  endtask
  task automatic test_timeout();
    do_reset();
    for (int c = 0; c < 7; c++) begin
      imem_ready = 0;
      #1;
      checks++;
      if (t_stage !== (c < 4 ? 3'd0 : 3'd5) || t_outs !== (c < 4 ? b(O_IREQ) : b(O_HLT))) begin
        errors++; $display("FAIL imem_timeout c%0d stage/strobes got %0d/%b", c, t_stage, t_outs);
      end
      checks++;
      if (t_bus_error !== (c >= 4)) begin
        errors++; $display("FAIL imem_timeout c%0d bus_error got %b exp %b", c, t_bus_error, c >= 4);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_ready_at_limit();
    logic [12:0] oe[5];
    oe = '{b(O_IREQ), b(O_IREQ), b(O_IREQ), b(O_IREQ) | b(O_IRL) | b(O_PCI), b(O_RFR)};
    do_reset();
    opcode = OP_NOP;
    for (int c = 0; c < 5; c++) begin
      imem_ready = c == 3;
      #1;
      checks++;
      if (t_stage !== (c < 4 ? 3'd0 : 3'd1) || t_outs !== oe[c] || t_bus_error !== 1'b0) begin
        errors++; $display("FAIL ready_at_limit c%0d got %0d/%b/%b exp %0d/%b/0", c, t_stage, t_outs,
                           t_bus_error, c < 4 ? 0 : 1, oe[c]);
      end
      @(negedge clk);
    end
  endtask
  task automatic test_mem_timeout();
    int se[8];
    logic [12:0] oe[8];
    se = '{0, 1, 2, 3, 3, 3, 3, 5};
    oe = '{b(O_IREQ) | b(O_IRL) | b(O_PCI), b(O_RFR), b(O_ALS), b(O_DRQ), b(O_DRQ), b(O_DRQ), b(O_DRQ), b(O_HLT)};
    do_reset();
    opcode = OP_LW;
    for (int c = 0; c < 8; c++) begin
      imem_ready = c == 0; dmem_ready = 0;
      #1;
      checks++;
      if (t_stage !== 3'(se[c]) || t_outs !== oe[c] || t_bus_error !== (c == 7)) begin
        errors++; $display("FAIL mem_timeout c%0d got %0d/%b/%b exp %0d/%b/%b", c, t_stage, t_outs,
                           t_bus_error, se[c], oe[c], c == 7);
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_r_type();
    test_alu_busy();
    test_lw_sw();
    test_flow();
    test_illegal();
    test_back_to_back();
    test_reset_mid_mem();
    test_halt();
    test_timeout();
    test_ready_at_limit();
    test_mem_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
